// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DIV_W = 4;

   // All-ones quotient reported for a zero divisor; sliced to the active width.
   localparam logic [31:0] DIV0_ONES = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the partial remainder
// left by one quotient bit and subtract the divisor if it fits.
module div_step
   import div_pkg::*;
#(
   parameter int W = DIV_W
)
(
   input  logic [W:0]   rem,
   input  logic [W-1:0] quo,
   input  logic [W-1:0] div,
   output logic [W:0]   rem_next,
   output logic [W-1:0] quo_next
);

   logic [W:0] shifted;
   logic [W:0] diff;

   // The extra remainder bit keeps the shifted value from wrapping before the compare.
   always_comb begin
      shifted  = (rem << 1) | (W+1)'(quo[W-1]);
      diff     = shifted - {1'b0, div};
      quo_next = quo << 1;
      rem_next = shifted;
      if (shifted >= {1'b0, div}) begin
         rem_next    = diff;
         quo_next[0] = 1'b1;
      end
   end

endmodule

// File: rtl/div.sv
// Sequential unsigned restoring divider producing one quotient bit per clock,
// started by a level request and reporting results with a finish flag.
module div
   import div_pkg::*;
#(
   parameter int W = DIV_W
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] numerador,
   input  logic [W-1:0] denominador,
   output logic [W-1:0] cociente,
   output logic [W-1:0] resto,
   output logic         finish
);

   localparam int CW = $clog2(W + 1);

   state_t         state;
   state_t         state_next;
   logic [W:0]     rem;
   logic [W:0]     rem_next;
   logic [W-1:0]   quo;
   logic [W-1:0]   quo_next;
   logic [W-1:0]   dvs;
   logic [CW-1:0]  cnt;
   logic           last_step;

   div_step #(.W(W)) u_step (
      .rem      (rem),
      .quo      (quo),
      .div      (dvs),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   assign last_step = (state == CALC) && (cnt == CW'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A held start keeps us in DONE so one button press yields exactly one result.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (denominador == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (!start) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         cnt      <= '0;
         cociente <= '0;
         resto    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (denominador == '0) begin
                     cociente <= DIV0_ONES[W-1:0];
                     resto    <= numerador;
                  end else begin
                     rem <= '0;
                     quo <= numerador;
                     dvs <= denominador;
                     cnt <= CW'(W);
                  end
               end
            end
            CALC: begin
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt - CW'(1);
               if (last_step) begin
                  cociente <= quo_next;
                  resto    <= rem_next[W-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      finish = (state == DONE);
   end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the restoring divider against a plain arithmetic model.
module tb_div;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] numerador;
   logic [W-1:0] denominador;
   logic [W-1:0] cociente;
   logic [W-1:0] resto;
   logic         finish;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div #(.W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .numerador   (numerador),
      .denominador (denominador),
      .cociente    (cociente),
      .resto       (resto),
      .finish      (finish)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Called at a negedge; raises start and counts rising edges until finish (bounded).
   task automatic applyStimulus(input logic [W-1:0] n, input logic [W-1:0] d,
                                input bit scramble, output int edges);
      numerador   = n;
      denominador = d;
      start       = 1'b1;
      edges       = 0;
      do begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (scramble && edges == 1) begin
            numerador   = W'($urandom);
            denominador = W'($urandom);
         end
      end while (!finish && edges < 20);
   endtask

   task automatic runCase(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                          input bit scramble, input int hold_cycles);
      int          edges;
      logic [31:0] exp_q;
      logic [31:0] exp_r;
      applyStimulus(n, d, scramble, edges);
      if (d == 0) begin
         exp_q = (32'd1 << W) - 1;
         exp_r = 32'(n);
      end else begin
         exp_q = 32'(n) / 32'(d);
         exp_r = 32'(n) % 32'(d);
      end
      checkOutput({tag, " latency"}, edges, (d == 0) ? 1 : W + 1);
      checkOutput({tag, " finish"}, finish, 1);
      checkOutput({tag, " cociente"}, cociente, exp_q);
      checkOutput({tag, " resto"}, resto, exp_r);
      if (d != 0) begin
         checkOutput({tag, " invariant"}, 32'(cociente) * 32'(d) + 32'(resto), 32'(n));
      end
      for (int i = 0; i < hold_cycles; i++) begin
         @(negedge clk);
         checkOutput({tag, " hold finish"}, finish, 1);
         checkOutput({tag, " hold cociente"}, cociente, exp_q);
      end
      start = 1'b0;
      @(negedge clk);
      checkOutput({tag, " finish drop"}, finish, 0);
      @(negedge clk);
      checkOutput({tag, " idle cociente"}, cociente, exp_q);
      checkOutput({tag, " idle resto"}, resto, exp_r);
   endtask

   initial begin
      logic [W-1:0] rn;
      logic [W-1:0] rd;
      rst         = 1'b0;
      start       = 1'b0;
      numerador   = '0;
      denominador = '0;
      #1;
      checkOutput("reset cociente", cociente, 0);
      checkOutput("reset resto", resto, 0);
      checkOutput("reset finish", finish, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      $display("[TB] directed cases");
      runCase("8/2", 4'd8, 4'd2, 1'b0, 0);
      runCase("8/0", 4'd8, 4'd0, 1'b0, 0);
      runCase("15/4", 4'd15, 4'd4, 1'b0, 0);
      runCase("3/5", 4'd3, 4'd5, 1'b0, 0);
      runCase("15/1", 4'd15, 4'd1, 1'b0, 0);
      runCase("13/3 held", 4'd13, 4'd3, 1'b0, 30);

      $display("[TB] reset during calculation");
      numerador   = 4'd15;
      denominador = 4'd4;
      start       = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("abort cociente", cociente, 0);
      checkOutput("abort resto", resto, 0);
      checkOutput("abort finish", finish, 0);
      @(negedge clk);
      rst = 1'b1;
      runCase("9/3 after reset", 4'd9, 4'd3, 1'b0, 0);

      $display("[TB] random operands changed during calculation");
      for (int i = 0; i < 24; i++) begin
         rn = W'($urandom);
         rd = W'($urandom_range(0, (1 << W) - 1));
         runCase("random", rn, rd, 1'b1, 0);
      end

      $display("[TB] exhaustive sweep");
      for (int n = 0; n < (1 << W); n++) begin
         for (int d = 0; d < (1 << W); d++) begin
            runCase("sweep", W'(n), W'(d), 1'b0, 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
